// File: rtl/regfile_mp_pkg.sv
// Shared constants for the multi-port register file: default widths,
// the zero word, the parity-bit width and the clear-sweep FSM encoding.
// Optional feature macro: REGFILE_PARITY_EN (adds one parity bit per entry).
package regfile_mp_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;

    localparam logic [RF_DATA_W-1:0] RF_ZERO_WORD = '0;

`ifdef REGFILE_PARITY_EN
    localparam int RF_PAR_W = 1;
`else
    localparam int RF_PAR_W = 0;
`endif

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: picks array contents or same-cycle write data
// (highest-index matching writer wins), forces reg 0 to zero when hardwired,
// and with REGFILE_PARITY_EN checks the stored parity of the selected entry.
module regfile_rd_port
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int N_WR     = 1,
    parameter int ZERO_REG = 1,
    parameter int ENTRY_W  = DATA_W + RF_PAR_W
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [ADDR_W-1:0]        raddr_i,
    input  logic [ENTRY_W-1:0]       entry_i,
    input  logic [N_WR-1:0]          we_acc_i,
    input  logic [N_WR*ADDR_W-1:0]   waddr_i,
    input  logic [N_WR*DATA_W-1:0]   wdata_i,
`ifdef REGFILE_PARITY_EN
    output logic                     par_err_o,
`endif
    output logic [DATA_W-1:0]        rdata_o
);

    logic [DATA_W-1:0] rdata_d, rdata_q;
`ifdef REGFILE_PARITY_EN
    logic              par_err_d, par_err_q;
`endif

    // Select array contents, bypassed write data or the hardwired zero.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        rdata_d = entry_i[DATA_W-1:0];
`ifdef REGFILE_PARITY_EN
        // Stored bit equals XOR of data, so a consistent entry XORs to 0.
        par_err_d = ^entry_i;
`endif
        for (int k = 0; k < N_WR; k++) begin
            if (we_acc_i[k] && (waddr_i[k*ADDR_W +: ADDR_W] == raddr_i)) begin
                rdata_d = wdata_i[k*DATA_W +: DATA_W];
`ifdef REGFILE_PARITY_EN
                par_err_d = 1'b0;
`endif
            end
        end
        if ((ZERO_REG != 0) && (raddr_i == '0)) begin
            rdata_d = DATA_W'(RF_ZERO_WORD);
`ifdef REGFILE_PARITY_EN
            par_err_d = 1'b0;
`endif
        end
    end

    // Output register: one cycle of read latency.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
        if (!rst_ni) begin
            rdata_q <= '0;
`ifdef REGFILE_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            rdata_q <= rdata_d;
`ifdef REGFILE_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    assign rdata_o = rdata_q;
`ifdef REGFILE_PARITY_EN
    assign par_err_o = par_err_q;
`endif

endmodule

// File: rtl/regfile_mp.sv
// Parametrised N_RD-read / N_WR-write register file with synchronous reads,
// same-cycle write bypass and a DEPTH-cycle hardware clear sweep (busy_o).
// Optional feature macro: REGFILE_PARITY_EN (per-entry even parity, par_err_o).
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int N_RD     = 2,
    parameter int N_WR     = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [N_WR-1:0]          we_i,
    input  logic [N_WR*ADDR_W-1:0]   waddr_i,
    input  logic [N_WR*DATA_W-1:0]   wdata_i,
    input  logic [N_RD*ADDR_W-1:0]   raddr_i,
    input  logic                     clr_i,
    output logic                     busy_o,
`ifdef REGFILE_PARITY_EN
    output logic [N_RD-1:0]          par_err_o,
`endif
    output logic [N_RD*DATA_W-1:0]   rdata_o
);

    localparam int DEPTH   = 2**ADDR_W;
    localparam int ENTRY_W = DATA_W + RF_PAR_W;

    rf_state_e          state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic [N_WR-1:0]    we_acc;

    // Writes land only in IDLE without a clear request, and never on hardwired reg 0.
    always_comb begin
        we_acc = '0;
        for (int k = 0; k < N_WR; k++) begin
            we_acc[k] = we_i[k] && (state_q == RF_IDLE) && !clr_i &&
                        !((ZERO_REG != 0) && (waddr_i[k*ADDR_W +: ADDR_W] == '0));
        end
    end

    // FSM state register and sweep pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RF_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state: one entry cleared per cycle, back to IDLE after the last one.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            RF_IDLE: begin
                if (clr_i) begin
                    state_d = RF_CLEAR;
                    ptr_d   = '0;
                end
            end
            RF_CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == ADDR_W'(DEPTH-1)) begin
                    state_d = RF_IDLE;
                    ptr_d   = '0;
                end
            end
            default: state_d = RF_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy_o = (state_q == RF_CLEAR);
    end

    // Array next value: sweep clear, else accepted writes in port order (highest wins).
    always_comb begin
        mem_d = mem_q;
        if (state_q == RF_CLEAR) begin
            mem_d[ptr_q] = '0;
        end else begin
            for (int k = 0; k < N_WR; k++) begin
                if (we_acc[k]) begin
`ifdef REGFILE_PARITY_EN
                    mem_d[waddr_i[k*ADDR_W +: ADDR_W]] =
                        {^wdata_i[k*DATA_W +: DATA_W], wdata_i[k*DATA_W +: DATA_W]};
`else
                    mem_d[waddr_i[k*ADDR_W +: ADDR_W]] = wdata_i[k*DATA_W +: DATA_W];
`endif
                end
            end
        end
    end

    // Storage array.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: the array is reset because reset must leave every entry at zero, like a full clear.
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    for (genvar j = 0; j < N_RD; j++) begin : g_rd
        regfile_rd_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .N_WR     (N_WR),
            .ZERO_REG (ZERO_REG),
            .ENTRY_W  (ENTRY_W)
        ) u_rd_port (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .raddr_i  (raddr_i[j*ADDR_W +: ADDR_W]),
            .entry_i  (mem_q[raddr_i[j*ADDR_W +: ADDR_W]]),
            .we_acc_i (we_acc),
            .waddr_i  (waddr_i),
            .wdata_i  (wdata_i),
`ifdef REGFILE_PARITY_EN
            .par_err_o(par_err_o[j]),
`endif
            .rdata_o  (rdata_o[j*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (2 read ports, 2 write ports, ZERO_REG=1).
// Expected read data and busy state come from a behavioural model and are
// queued when stimulus is driven, then popped after the clock edge.
module tb_regfile_mp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int N_RD   = 2;
    localparam int N_WR   = 2;
    localparam int DEPTH  = 32;

    logic                   clk_i = 1'b0;
    logic                   rst_ni = 1'b0;
    logic [N_WR-1:0]        we_i = '0;
    logic [N_WR*ADDR_W-1:0] waddr_i = '0;
    logic [N_WR*DATA_W-1:0] wdata_i = '0;
    logic [N_RD*ADDR_W-1:0] raddr_i = '0;
    logic                   clr_i = 1'b0;
    logic                   busy_o;
    logic [N_RD*DATA_W-1:0] rdata_o;
`ifdef REGFILE_PARITY_EN
    logic [N_RD-1:0]        par_err_o;
`endif

    regfile_mp #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .N_RD     (N_RD),
        .N_WR     (N_WR),
        .ZERO_REG (1)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .we_i     (we_i),
        .waddr_i  (waddr_i),
        .wdata_i  (wdata_i),
        .raddr_i  (raddr_i),
        .clr_i    (clr_i),
        .busy_o   (busy_o),
`ifdef REGFILE_PARITY_EN
        .par_err_o(par_err_o),
`endif
        .rdata_o  (rdata_o)
    );

    always #5 clk_i = ~clk_i;

    // kind 0/1: read port index; kind 2: busy_o
    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl [DEPTH];
    logic        mdl_busy;
    int          mdl_ptr;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        mdl_busy = 1'b0;
        mdl_ptr  = 0;
        sb.delete();
    endtask

    // Called at a negedge: drives one cycle, queues expectations, returns at the next negedge.
    task automatic drive_cycle(input logic [1:0] we,
                               input logic [4:0] wa0, input logic [31:0] wd0,
                               input logic [4:0] wa1, input logic [31:0] wd1,
                               input logic [4:0] ra0, input logic [4:0] ra1,
                               input logic clr, input string tag);
        logic [4:0]  wa[2];
        logic [31:0] wd[2];
        logic [4:0]  ra[2];
        logic        acc[2];
        logic [31:0] e;
        wa[0] = wa0; wa[1] = wa1; wd[0] = wd0; wd[1] = wd1; ra[0] = ra0; ra[1] = ra1;
        we_i = we; waddr_i = {wa1, wa0}; wdata_i = {wd1, wd0}; raddr_i = {ra1, ra0}; clr_i = clr;
        for (int k = 0; k < 2; k++) acc[k] = we[k] && !mdl_busy && !clr && (wa[k] != 5'd0);
        for (int j = 0; j < 2; j++) begin
            e = mdl[ra[j]];
            for (int k = 0; k < 2; k++) if (acc[k] && wa[k] == ra[j]) e = wd[k];
            if (ra[j] == 5'd0) e = '0;
            sb.push_back('{tag, j, e});
        end
        if (mdl_busy) begin
            mdl[mdl_ptr] = '0;
            if (mdl_ptr == DEPTH-1) begin
                mdl_busy = 1'b0;
                mdl_ptr  = 0;
            end else begin
                mdl_ptr++;
            end
        end else if (clr) begin
            mdl_busy = 1'b1;
            mdl_ptr  = 0;
        end else begin
            for (int k = 0; k < 2; k++) if (acc[k]) mdl[wa[k]] = wd[k];
        end
        sb.push_back('{tag, 2, {31'b0, mdl_busy}});
        @(posedge clk_i);
        @(negedge clk_i);
        we_i  = '0;
        clr_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_i);
        n_tests++;
        if (rdata_o !== '0) begin
            n_fail++; $display("FAIL reset_rdata: got %h, expected 0", rdata_o);
        end
        n_tests++;
        if (busy_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy_o);
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_write_read();
        exp_t e; logic [31:0] got;
        for (int c = 0; c < 4; c++) begin
            case (c)
                0: drive_cycle(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 5'd6, 5'd5, 1'b0, "wr_r5");
                1: drive_cycle(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd6, 1'b0, "rd_r5_r6");
                2: drive_cycle(2'b10, 5'd0, 32'h0, 5'd6, 32'h0BADF00D, 5'd6, 5'd6, 1'b0, "wr_r6_p1");
                default: drive_cycle(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd6, 5'd5, 1'b0, "rd_r6_r5");
            endcase
            while (sb.size() != 0) begin
                e = sb.pop_front();
                got = (e.kind == 2) ? {31'b0, busy_o} : rdata_o[e.kind*32 +: 32];
                n_tests++;
                if (got !== e.data) begin
                    n_fail++; $display("FAIL %s kind%0d: got %h, expected %h", e.tag, e.kind, got, e.data);
                end
            end
        end
    endtask

    task automatic test_bypass_zero_conflict();
        exp_t e; logic [31:0] got;
        for (int c = 0; c < 6; c++) begin
            case (c)
                0: drive_cycle(2'b01, 5'd7, 32'h1234, 5'd0, 32'h0, 5'd7, 5'd7, 1'b0, "bypass_r7");
                1: drive_cycle(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 5'd5, 1'b0, "rd_r7");
                2: drive_cycle(2'b11, 5'd0, 32'hFFFF, 5'd0, 32'hFFFF, 5'd0, 5'd0, 1'b0, "wr_r0");
                3: drive_cycle(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd7, 1'b0, "rd_r0");
                4: drive_cycle(2'b11, 5'd3, 32'hA, 5'd3, 32'hB, 5'd3, 5'd3, 1'b0, "conflict_r3");
                default: drive_cycle(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd0, 1'b0, "rd_r3");
            endcase
            while (sb.size() != 0) begin
                e = sb.pop_front();
                got = (e.kind == 2) ? {31'b0, busy_o} : rdata_o[e.kind*32 +: 32];
                n_tests++;
                if (got !== e.data) begin
                    n_fail++; $display("FAIL %s kind%0d: got %h, expected %h", e.tag, e.kind, got, e.data);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e; logic [31:0] got;
        logic [4:0] wa0, wa1;
        for (int c = 0; c < 60; c++) begin
            wa0 = 5'($urandom_range(31));
            wa1 = 5'($urandom_range(31));
            drive_cycle(2'($urandom_range(3)), wa0, $urandom, wa1, $urandom,
                        ($urandom_range(1) != 0) ? wa0 : 5'($urandom_range(31)),
                        ($urandom_range(1) != 0) ? wa1 : 5'($urandom_range(31)),
                        1'b0, "b2b");
            while (sb.size() != 0) begin
                e = sb.pop_front();
                got = (e.kind == 2) ? {31'b0, busy_o} : rdata_o[e.kind*32 +: 32];
                n_tests++;
                if (got !== e.data) begin
                    n_fail++; $display("FAIL %s cyc%0d kind%0d: got %h, expected %h", e.tag, c, e.kind, got, e.data);
                end
            end
        end
    endtask

    task automatic test_clear();
        exp_t e; logic [31:0] got;
        int busy_hi = 0;
        for (int c = 0; c < 16 + 1 + 32 + 16; c++) begin
            if (c < 16)
                drive_cycle(2'b11, 5'(2*c), 32'hC0DE0000 | c, 5'(2*c+1), 32'hF00D0000 | c,
                            5'(2*c), 5'(2*c+1), 1'b0, "fill");
            else if (c == 16)
                drive_cycle(2'b01, 5'd12, 32'h00000BAD, 5'd0, 32'h0, 5'd12, 5'd31, 1'b1, "clr_start");
            else if (c < 49)
                drive_cycle(2'b11, 5'($urandom_range(31)), $urandom, 5'($urandom_range(31)), $urandom,
                            5'($urandom_range(31)), 5'($urandom_range(31)), 1'($urandom_range(1)), "sweep");
            else
                drive_cycle(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'(2*(c-49)), 5'(2*(c-49)+1), 1'b0, "post_clr");
            if (c >= 16 && c < 49 && busy_o === 1'b1) busy_hi++;
            while (sb.size() != 0) begin
                e = sb.pop_front();
                got = (e.kind == 2) ? {31'b0, busy_o} : rdata_o[e.kind*32 +: 32];
                n_tests++;
                if (got !== e.data) begin
                    n_fail++; $display("FAIL %s cyc%0d kind%0d: got %h, expected %h", e.tag, c, e.kind, got, e.data);
                end
            end
        end
        n_tests++;
        if (busy_hi != DEPTH) begin
            n_fail++; $display("FAIL busy_len: got %0d cycles, expected %0d", busy_hi, DEPTH);
        end
    endtask

    task automatic test_reset_mid_sweep();
        exp_t e; logic [31:0] got;
        for (int c = 0; c < 8 + 1 + 10; c++) begin
            if (c < 8)
                drive_cycle(2'b11, 5'(c+1), $urandom, 5'(c+20), $urandom, 5'(c+1), 5'(c+20), 1'b0, "mid_fill");
            else
                drive_cycle(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd25, (c == 8), "mid_sweep");
            while (sb.size() != 0) begin
                e = sb.pop_front();
                got = (e.kind == 2) ? {31'b0, busy_o} : rdata_o[e.kind*32 +: 32];
                n_tests++;
                if (got !== e.data) begin
                    n_fail++; $display("FAIL %s cyc%0d kind%0d: got %h, expected %h", e.tag, c, e.kind, got, e.data);
                end
            end
        end
        rst_ni = 1'b0;
        #1;
        n_tests++;
        if (busy_o !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst_busy: got %b, expected 0", busy_o);
        end
        n_tests++;
        if (rdata_o !== '0) begin
            n_fail++; $display("FAIL mid_rst_rdata: got %h, expected 0", rdata_o);
        end
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int c = 0; c < 18; c++) begin
            if (c < 16)
                drive_cycle(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'(2*c), 5'(2*c+1), 1'b0, "after_rst");
            else if (c == 16)
                drive_cycle(2'b01, 5'd9, 32'h55, 5'd0, 32'h0, 5'd10, 5'd8, 1'b0, "wr_r9");
            else
                drive_cycle(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b0, "rd_r9");
            while (sb.size() != 0) begin
                e = sb.pop_front();
                got = (e.kind == 2) ? {31'b0, busy_o} : rdata_o[e.kind*32 +: 32];
                n_tests++;
                if (got !== e.data) begin
                    n_fail++; $display("FAIL %s cyc%0d kind%0d: got %h, expected %h", e.tag, c, e.kind, got, e.data);
                end
            end
        end
    endtask

`ifdef REGFILE_PARITY_EN
    task automatic test_parity();
        exp_t e; logic [31:0] got;
        for (int c = 0; c < 3; c++) begin
            case (c)
                0: drive_cycle(2'b01, 5'd4, 32'h3, 5'd0, 32'h0, 5'd4, 5'd0, 1'b0, "par_wr_r4");
                1: drive_cycle(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd4, 5'd9, 1'b0, "par_rd_r4");
                default: drive_cycle(2'b01, 5'd4, 32'h7, 5'd0, 32'h0, 5'd4, 5'd0, 1'b0, "par_byp_r4");
            endcase
            n_tests++;
            if (par_err_o !== ((c == 1) ? 2'b01 : 2'b00)) begin
                n_fail++; $display("FAIL par_err cyc%0d: got %b, expected %b", c, par_err_o, (c == 1) ? 2'b01 : 2'b00);
            end
            while (sb.size() != 0) begin
                e = sb.pop_front();
                got = (e.kind == 2) ? {31'b0, busy_o} : rdata_o[e.kind*32 +: 32];
                n_tests++;
                if (got !== e.data) begin
                    n_fail++; $display("FAIL %s kind%0d: got %h, expected %h", e.tag, e.kind, got, e.data);
                end
            end
            if (c == 0) begin
                // Corrupt data bit 0 of r4 without touching its parity bit.
                dut.mem_q[4][0] = ~dut.mem_q[4][0];
                mdl[4] = 32'h2;
            end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_bypass_zero_conflict();
        test_back_to_back();
        test_clear();
        test_reset_mid_sweep();
`ifdef REGFILE_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the pipelined core, replacing the fixed 2-read/1-write file.
- Generalised in data width, depth and number of read and write ports.
- Reads are synchronous on posedge and include same-cycle write bypass.
- Adds a hardware clear sweep with a busy flag, and an optional per-entry parity check.

Parameters:
- DATA_W, 32, entry width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- N_RD, 2, number of read ports.
- N_WR, 1, number of write ports (1..4).
- ZERO_REG, 1, when 1 entry 0 is hardwired to zero.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_ni  in  1  asynchronous active-low reset.
- we_i  in  N_WR  per-port write enable.
- waddr_i  in  N_WR*ADDR_W  write addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- wdata_i  in  N_WR*DATA_W  write data, packed the same way.
- raddr_i  in  N_RD*ADDR_W  read addresses, packed.
- rdata_o  out  N_RD*DATA_W  registered read data, packed.
- clr_i  in  1  one-cycle pulse that starts the clear sweep.
- busy_o  out  1  high while the clear sweep runs.
- par_err_o  out  N_RD  parity error per read port; present only with the optional feature.

Behaviour:
- Reset (async, rst_ni=0):
  - all entries = 0; rdata_o = 0; busy_o = 0; par_err_o = 0.
  - FSM goes to IDLE; clear pointer = 0.
  - Reset asserted mid-sweep aborts the sweep; the result is identical to a full clear.
- Write:
  - at posedge, if we_i[k] is set and the FSM is IDLE, entry waddr[k] <= wdata[k].
  - with ZERO_REG=1, writes to address 0 are dropped.
  - two ports writing the same address in one cycle: the highest-index port wins.
- Read:
  - 1-cycle latency: rdata_o[j] after posedge n = contents for raddr[j] sampled at edge n.
  - bypass: if a write to the same address is accepted at edge n, rdata_o[j] shows that new write data, not the old contents.
  - multiple matching writers: the highest-index port's data is bypassed.
  - ZERO_REG=1 and raddr=0: rdata_o[j] = 0, with no bypass.
  - read ports are fully independent; any address combination is legal.
- FSM states:
  - IDLE --clr_i--> CLEAR; clear pointer = 0.
  - CLEAR: each cycle, entry[ptr] <= 0 and ptr increments. At ptr == DEPTH-1, that entry is cleared and the FSM returns to IDLE.
  - the sweep takes exactly DEPTH cycles.
  - busy_o = 1 exactly while in CLEAR, i.e. from the edge after clr_i for DEPTH cycles.
- During CLEAR:
  - all we_i are ignored; no bypass.
  - reads return the current array contents (partially cleared).
  - clr_i is ignored.
- clr_i and we_i in the same IDLE cycle: the write is dropped, because clear has priority.
- Array width: DATA_W bits per entry, plus 1 parity bit when the optional feature is enabled.

Optional Feature:
- Macro: REGFILE_PARITY_EN.
- When defined:
  - each entry stores an extra even-parity bit, computed as the XOR of the written data.
  - the clear sweep and reset write data 0 with parity 0.
  - par_err_o[j] is registered alongside rdata_o[j] and is 1 when the stored parity mismatches the stored data.
  - bypassed reads and reads of reg 0 report par_err_o[j] = 0.
- When undefined:
  - no parity storage; the par_err_o port is omitted.
  - behaviour is otherwise identical.

Decomposition:
- Shared package / include (lagartoII constants):
  - default DATA_W and ADDR_W.
  - the zero-word constant.
  - FSM state encoding RF_IDLE=1'b0, RF_CLEAR=1'b1.
- One sub-module, regfile_rd_port:
  - per-read-port bypass-match, zero-register and parity-check logic, plus the output register.
  - instantiated N_RD times with a generate loop.

Test Plan:
- Reset then write: pulse rst_ni low; write 0xDEADBEEF to r5. Reading r5 the next cycle -> 0xDEADBEEF; a read of r6 -> 0.
- Bypass: write r7=0x1234 and read r7 in the same cycle -> rdata_o = 0x1234 after that edge, not the old value 0.
- Zero register and conflict: write r0=0xFFFF -> reading r0 gives 0. With N_WR=2, port0 writes r3=0xA and port1 writes r3=0xB in the same cycle -> r3 reads 0xB.
- Clear sweep: fill all 32 entries, then pulse clr_i -> busy_o is high for exactly 32 cycles and writes during that window are ignored. Afterwards all entries read 0.
- Reset mid-sweep: assert rst_ni at sweep cycle 10 -> busy_o = 0 immediately and all entries read 0. A subsequent write to r9=0x55 succeeds.
- Parity (REGFILE_PARITY_EN): write r4=0x3; force-flip one stored bit; read r4 -> par_err_o[0] = 1. Reading an untouched entry -> par_err_o = 0.
